// File: rtl/pong_input_debounce.sv
// Paddle button conditioner: 2-flop synchroniser plus per-channel debounce counter.
// Optional PRESS_PULSE_EN macro adds a one-cycle press strobe output.
module pong_input_debounce #(
  parameter int unsigned CLK_HZ          = 25_175_000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [3:0] btn_n_raw,
  output logic [3:0] btn_n_clean
`ifdef PRESS_PULSE_EN
  ,
  output logic [3:0] press_pulse
`endif
);

  typedef enum logic {STABLE, CANDIDATE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1, s2;
  logic [3:0]       clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  state_e           state_q [4];
  state_e           state_d [4];

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      s1      <= '1;
      s2      <= '1;
      clean_q <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= STABLE;
      end
    end else begin
      s1      <= btn_n_raw;
      s2      <= s1;
      clean_q <= clean_d;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  // A candidate commits on its DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_comb begin
    clean_d = clean_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      if (s2[i] == clean_q[i]) begin
        cnt_d[i]   = '0;
        state_d[i] = STABLE;
      end else if (cnt_q[i] == CNT_LAST) begin
        clean_d[i] = s2[i];
        cnt_d[i]   = '0;
        state_d[i] = STABLE;
      end else begin
        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        state_d[i] = CANDIDATE;
      end
    end
  end

  assign btn_n_clean = clean_q;

`ifdef PRESS_PULSE_EN
  logic [3:0] clean_d1;

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      clean_d1    <= '1;
      press_pulse <= '0;
    end else begin
      clean_d1    <= clean_q;
      press_pulse <= clean_d1 & ~clean_q;
    end
  end
`endif

endmodule

// File: tb/tb_pong_input_debounce.sv
// Bench for pong_input_debounce with DEBOUNCE_CYCLES=8; table vectors plus hand sequences.
// Press-strobe checks are compiled in when PRESS_PULSE_EN is defined.
module tb_pong_input_debounce;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_n_raw = 4'b1111;
  logic [3:0] btn_n_clean;
`ifdef PRESS_PULSE_EN
  logic [3:0] press_pulse;
`endif

  pong_input_debounce #(.DEBOUNCE_CYCLES(8)) dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .btn_n_raw   (btn_n_raw),
    .btn_n_clean (btn_n_clean)
`ifdef PRESS_PULSE_EN
    ,
    .press_pulse (press_pulse)
`endif
  );

  always #5 clk_0 = ~clk_0;

  typedef struct {
    logic       r;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] pulse;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic void add(input logic r, input logic [3:0] raw,
                              input logic [3:0] clean, input logic [3:0] pulse);
    vecs.push_back('{r, raw, clean, pulse});
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic step(input logic r, input logic [3:0] raw, input logic [3:0] clean,
                      input logic [3:0] pulse, input string tag);
    vec_t e;
    rst       = r;
    btn_n_raw = raw;
    sb.push_back('{r, raw, clean, pulse});
    @(posedge clk_0);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (btn_n_clean !== e.clean) begin
      n_err++;
      $display("FAIL %s clean @%0t: got %b want %b", tag, $time, btn_n_clean, e.clean);
    end
`ifdef PRESS_PULSE_EN
    n_vec++;
    if (press_pulse !== e.pulse) begin
      n_err++;
      $display("FAIL %s pulse @%0t: got %b want %b", tag, $time, press_pulse, e.pulse);
    end
`endif
  endtask

  initial begin
    // reset with raw all pressed, then a one-cycle glitch after release
    for (int j = 0; j < 3; j++) add(1'b0, 4'b0000, 4'b1111, 4'b0000);
    add(1'b1, 4'b0000, 4'b1111, 4'b0000);
    for (int j = 0; j < 6; j++) add(1'b1, 4'b1111, 4'b1111, 4'b0000);
    // clean press of bit0: output moves 9 steps after capture, strobe one step later
    for (int j = 0; j <= 12; j++)
      add(1'b1, 4'b1110, (j >= 9) ? 4'b1110 : 4'b1111, (j == 10) ? 4'b0001 : 4'b0000);
    // bounce on bit1: two 7-cycle excursions must both be rejected
    for (int j = 0; j < 7; j++) add(1'b1, 4'b1100, 4'b1110, 4'b0000);
    add(1'b1, 4'b1110, 4'b1110, 4'b0000);
    for (int j = 0; j < 7; j++) add(1'b1, 4'b1100, 4'b1110, 4'b0000);
    for (int j = 0; j < 12; j++) add(1'b1, 4'b1110, 4'b1110, 4'b0000);
    // release of bit0, no strobe
    for (int j = 0; j <= 12; j++)
      add(1'b1, 4'b1111, (j >= 9) ? 4'b1111 : 4'b1110, 4'b0000);

    for (int v = 0; v < vecs.size(); v++)
      step(vecs[v].r, vecs[v].raw, vecs[v].clean, vecs[v].pulse, $sformatf("table[%0d]", v));

    // simultaneous bit0/bit2 press, bit2 bounces high at step 4
    for (int j = 0; j < 18; j++)
      step(1'b1, (j == 4) ? 4'b1110 : 4'b1010,
           (j < 9) ? 4'b1111 : ((j < 14) ? 4'b1110 : 4'b1010),
           (j == 10) ? 4'b0001 : ((j == 15) ? 4'b0100 : 4'b0000), "simul");
    for (int j = 0; j <= 12; j++)
      step(1'b1, 4'b1111, (j >= 9) ? 4'b1111 : 4'b1010, 4'b0000, "simul_rel");

    // bit3 held low, reset once the counter has reached 5
    for (int j = 0; j < 7; j++) step(1'b1, 4'b0111, 4'b1111, 4'b0000, "midcnt");
    step(1'b0, 4'b0111, 4'b1111, 4'b0000, "midcnt_rst");
    for (int j = 0; j <= 11; j++)
      step(1'b1, 4'b0111, (j >= 9) ? 4'b0111 : 4'b1111,
           (j == 10) ? 4'b1000 : 4'b0000, "after_rst");
    // reset while pressed returns to released, then full filter time again
    step(1'b0, 4'b0111, 4'b1111, 4'b0000, "held_rst");
    for (int j = 0; j <= 11; j++)
      step(1'b1, 4'b0111, (j >= 9) ? 4'b0111 : 4'b1111,
           (j == 10) ? 4'b1000 : 4'b0000, "after_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
